// File: rtl/bullet.sv
// bullet: 16-slot falling-bullet engine with frame-tick motion and registered per-slot readout
module bullet #(
  parameter int NUM_ACTIVE   = 8,
  parameter int TICK_DIV     = 4,
  parameter int ARENA_TOP    = 8,
  parameter int ARENA_BOTTOM = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  index,
  output logic [31:0] state,
  output logic [15:0] position,
  output logic [15:0] size,
  output logic [2:0]  color,
  output logic        isRender
);
  logic [7:0]  x [16];
  logic [7:0]  y [16];
  logic [7:0]  w [16];
  logic [7:0]  h [16];
  logic [2:0]  vy [16];
  logic [2:0]  col [16];
  logic [8:0]  yn [16];
  logic [15:0] active;
  logic [15:0] frame_count;
  logic [15:0] div;
  logic        tick;
  always_comb begin
    tick = div == 16'(TICK_DIV - 1);
    for (int i = 0; i < 16; i++) yn[i] = 9'(y[i]) + 9'(vy[i]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      frame_count <= '0;
      state <= '0;
      position <= '0;
      size <= '0;
      color <= '0;
      isRender <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        x[i] <= 8'(16 * i + 4);
        y[i] <= 8'(ARENA_TOP);
        w[i] <= 8'(4 + 2 * (i % 4));
        h[i] <= 8'(4 + 2 * (i % 4));
        vy[i] <= 3'(1 + i % 4);
        col[i] <= (i % 8 == 0) ? 3'b111 : 3'(i % 8);
        active[i] <= i < NUM_ACTIVE;
      end
    end else begin
      div <= tick ? '0 : div + 16'd1;
      frame_count <= frame_count + 16'(tick);
      state <= {active, frame_count};
      position <= {x[index], y[index]};
      size <= {w[index], h[index]};
      color <= col[index];
      isRender <= active[index];
      for (int i = 0; i < 16; i++)
        if (tick && active[i]) y[i] <= (yn[i] > 9'(ARENA_BOTTOM)) ? 8'(ARENA_TOP) : yn[i][7:0];
    end
  end
endmodule

// File: tb/tb_bullet.sv
// tb_bullet: scoreboard + vector-table bench for bullet
module tb_bullet;
  localparam int NA = 8, TD = 4, TOP = 8, BOT = 200;
  logic        clk, reset;
  logic [3:0]  index;
  logic [31:0] state, state16;
  logic [15:0] position, size, position16, size16;
  logic [2:0]  color, color16;
  logic        isRender, isRender16;
  int checks = 0, errors = 0;

  bullet #(.NUM_ACTIVE(NA), .TICK_DIV(TD), .ARENA_TOP(TOP), .ARENA_BOTTOM(BOT)) dut (
    .clk(clk), .reset(reset), .index(index), .state(state), .position(position),
    .size(size), .color(color), .isRender(isRender));
  bullet #(.NUM_ACTIVE(16), .TICK_DIV(TD), .ARENA_TOP(TOP), .ARENA_BOTTOM(BOT)) dut16 (
    .clk(clk), .reset(reset), .index(index), .state(state16), .position(position16),
    .size(size16), .color(color16), .isRender(isRender16));

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] st;
    logic [15:0] pos;
    logic [15:0] sz;
    logic [2:0]  col;
    logic        ren;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] pos;
    logic [15:0] sz;
    logic [2:0]  col;
    logic        r8;
    logic        r16;
  } vec_t;
  vec_t vt[8];

  int my[16];
  int mdiv, mfc;
  logic [15:0] mact;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic cycle();
    exp_t e;
    int i, n;
    i = int'(index);
    if (reset) e = '0;
    else begin
      e.st = {mact, 16'(mfc)};
      e.pos = {8'(16 * i + 4), 8'(my[i])};
      e.sz = {8'(4 + 2 * (i % 4)), 8'(4 + 2 * (i % 4))};
      e.col = (i % 8 == 0) ? 3'b111 : 3'(i % 8);
      e.ren = mact[i];
    end
    sb.push_back(e);
    if (reset) begin
      for (int k = 0; k < 16; k++) my[k] = TOP;
      mdiv = 0;
      mfc = 0;
    end else if (mdiv == TD - 1) begin
      mdiv = 0;
      mfc = (mfc + 1) % 65536;
      for (int k = 0; k < 16; k++)
        if (mact[k]) begin
          n = my[k] + 1 + k % 4;
          my[k] = (n > BOT) ? TOP : n;
        end
    end else mdiv++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_state", state, e.st);
    chk("sb_position", {16'd0, position}, {16'd0, e.pos});
    chk("sb_size", {16'd0, size}, {16'd0, e.sz});
    chk("sb_color", {29'd0, color}, {29'd0, e.col});
    chk("sb_isRender", {31'd0, isRender}, {31'd0, e.ren});
  endtask

  initial begin
    for (int k = 0; k < 16; k++) mact[k] = k < NA;
    for (int k = 0; k < 16; k++) my[k] = TOP;
    mdiv = 0;
    mfc = 0;
    vt[0] = '{4'd0,  16'h0408, 16'h0404, 3'b111, 1'b1, 1'b1};
    vt[1] = '{4'd1,  16'h1408, 16'h0606, 3'b001, 1'b1, 1'b1};
    vt[2] = '{4'd2,  16'h2408, 16'h0808, 3'b010, 1'b1, 1'b1};
    vt[3] = '{4'd3,  16'h3408, 16'h0A0A, 3'b011, 1'b1, 1'b1};
    vt[4] = '{4'd7,  16'h7408, 16'h0A0A, 3'b111, 1'b1, 1'b1};
    vt[5] = '{4'd8,  16'h8408, 16'h0404, 3'b111, 1'b0, 1'b1};
    vt[6] = '{4'd9,  16'h9408, 16'h0606, 3'b001, 1'b0, 1'b1};
    vt[7] = '{4'd15, 16'hF408, 16'h0A0A, 3'b111, 1'b0, 1'b1};
    reset = 1;
    index = 0;
    for (int v = 0; v < 8; v++) begin
      reset = 1;
      cycle();
      reset = 0;
      index = vt[v].idx;
      cycle();
      chk("tbl_position", {16'd0, position}, {16'd0, vt[v].pos});
      chk("tbl_size", {16'd0, size}, {16'd0, vt[v].sz});
      chk("tbl_color", {29'd0, color}, {29'd0, vt[v].col});
      chk("tbl_isRender", {31'd0, isRender}, {31'd0, vt[v].r8});
      chk("tbl16_position", {16'd0, position16}, {16'd0, vt[v].pos});
      chk("tbl16_size", {16'd0, size16}, {16'd0, vt[v].sz});
      chk("tbl16_color", {29'd0, color16}, {29'd0, vt[v].col});
      chk("tbl16_isRender", {31'd0, isRender16}, {31'd0, vt[v].r16});
      chk("tbl16_state", state16, 32'hFFFF_0000);
    end
    reset = 1;
    index = 0;
    cycle();
    cycle();
    chk("rst_position", {16'd0, position}, 32'd0);
    chk("rst_state", state, 32'd0);
    chk("rst_isRender", {31'd0, isRender}, 32'd0);
    reset = 0;
    cycle();
    chk("rel_position", {16'd0, position}, 32'h0000_0408);
    chk("rel_size", {16'd0, size}, 32'h0000_0404);
    chk("rel_state", state, 32'h00FF_0000);
    index = 1;
    cycle();
    chk("idx1_position", {16'd0, position}, 32'h0000_1408);
    chk("idx1_color", {29'd0, color}, 32'd1);
    repeat (3) cycle();
    chk("tick1_position", {16'd0, position}, 32'h0000_140A);
    chk("tick1_frame", {16'd0, state[15:0]}, 32'd1);
    index = 9;
    repeat (40) cycle();
    chk("frozen_position", {16'd0, position}, 32'h0000_9408);
    chk("frozen_isRender", {31'd0, isRender}, 32'd0);
    reset = 1;
    cycle();
    reset = 0;
    index = 3;
    repeat (193) cycle();
    chk("wrap48_position", {16'd0, position}, 32'h0000_34C8);
    repeat (4) cycle();
    chk("wrap49_position", {16'd0, position}, 32'h0000_3408);
    reset = 1;
    cycle();
    reset = 0;
    index = 1;
    repeat (80) cycle();
    reset = 1;
    cycle();
    chk("midrst_position", {16'd0, position}, 32'd0);
    chk("midrst_state", state, 32'd0);
    reset = 0;
    cycle();
    chk("midrel_position", {16'd0, position}, 32'h0000_1408);
    chk("midrel_state", state, 32'h00FF_0000);
    repeat (60) begin
      index = 4'($urandom_range(0, 15));
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bullet.md
Name: bullet

Overview:
- Bullet-pattern engine for the battle arena: holds 16 bullet slots (position, size, colour, fall speed, active flag) and advances them on an internal frame tick.
- The renderer supplies a slot `index`; the block returns that slot's geometry, colour and render-enable, registered.
- A 32-bit `state` word exposes the global active mask and frame counter to the game controller.

Parameters:
- NUM_ACTIVE, 8, number of slots (indices 0..NUM_ACTIVE-1) active after reset; range 0..16.
- TICK_DIV, 4, clk cycles per frame tick; must be ≥1.
- ARENA_TOP, 8, y value a bullet is loaded with at reset and on wrap.
- ARENA_BOTTOM, 200, largest legal y; a move that would exceed it wraps to ARENA_TOP.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- index  input  4  slot selected for readout.
- state  output  32  {active_mask[15:0], frame_count[15:0]}.
- position  output  16  {x[7:0], y[7:0]} of the selected slot.
- size  output  16  {w[7:0], h[7:0]} of the selected slot.
- color  output  3  RGB colour of the selected slot.
- isRender  output  1  1 when the selected slot is active.

Behaviour:
- Per-slot storage for i = 0..15:
  - x, y, w, h: 8 bits each.
  - vy: 3 bits.
  - color: 3 bits.
  - active: 1 bit.
- Reset table, loaded on any clk edge with reset=1, including mid-operation:
  - x_i = 16*i + 4; y_i = ARENA_TOP.
  - w_i = h_i = 4 + 2*i[1:0], giving 4, 6, 8 or 10.
  - vy_i = 1 + i[1:0].
  - color_i = i[2:0], except colour 3'b000 is replaced by 3'b111.
  - active_i = (i < NUM_ACTIVE).
- Also on reset: frame_count=0, divider=0, and every output register clears to 0.
- Tick divider:
  - Counts 0..TICK_DIV-1, then returns to 0.
  - tick is asserted in the cycle the divider equals TICK_DIV-1.
  - The first tick is therefore the TICK_DIV-th rising edge after reset deasserts.
- On tick:
  - frame_count increments, wrapping 16'hFFFF→0.
  - Every active slot computes y_next = y + vy in 9-bit arithmetic.
  - If y_next > ARENA_BOTTOM, y ← ARENA_TOP; otherwise y ← y_next[7:0].
  - x, w, h, color never change after reset.
  - Inactive slots are frozen.
  - All slots update in parallel in the same cycle.
- Readout:
  - position, size, color and isRender are registered from slot[index], giving 1-cycle latency.
  - The value reflects slot contents before any update in that same edge, i.e. the previous cycle's stored values.
  - index may change every cycle.
  - An inactive slot still reports its stored geometry, with isRender=0.
- state is registered: {active_mask, frame_count}, same 1-cycle latency as the other outputs.
- No handshakes: the outputs are pure registered lookups.
- Simultaneous reset and tick: reset wins.

Test Plan:
- Reset asserted 2 cycles, then index=0:
  - All outputs are 0 during reset.
  - One cycle after release: position=16'h0408, size=16'h0404, color=3'b111, isRender=1, state=32'h00FF_0000.
- index=1 applied 10 ns after release (TICK_DIV=4):
  - Next edge: position=16'h1408, size=16'h0606, color=3'b001, isRender=1.
  - After the first tick (the 4th edge), position=16'h140A and state[15:0]=1.
- index=9:
  - position=16'h9408, size=16'h0606, color=3'b001, isRender=0.
  - Value unchanged across 10 ticks (frozen slot).
- Wrap with index=3 (vy=4):
  - After 48 ticks, position=16'h34C8 (y=200).
  - 49th tick gives position=16'h3408 (8+4*49=204 > 200 → ARENA_TOP).
- Reset mid-run after 20 ticks:
  - Next edge clears all outputs and restores the table.
  - frame_count=0; slot 1 reads 16'h1408 again.
- NUM_ACTIVE=16:
  - state[31:16]=16'hFFFF after reset.
  - index=15 gives isRender=1, position=16'hF408, size=16'h0A0A, color=3'b111.
